// File: rtl/router_fifo.sv
// Per-destination output buffer of the 1x3 router: header-tagged byte FIFO
// with read-side packet length tracking so d_out idles at zero between packets.
module router_fifo #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             soft_rst,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W   = ADDR_W + 1;
  localparam int unsigned ENTRY_W = WIDTH + 1;
  localparam int unsigned CNT_W   = 6;
  localparam int unsigned LEN_MSB = 7;
  localparam int unsigned LEN_LSB = 2;

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   pkt_count_q, pkt_count_d;
  logic [WIDTH-1:0]   d_out_q, d_out_d;
  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic               wr_accept_c;
  logic               rd_accept_c;
  logic [ENTRY_W-1:0] rd_entry_c;

  // Occupancy flags straight from the registered pointers.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                 (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

  assign wr_accept_c = wr_en && !full && !soft_rst;
  assign rd_accept_c = rd_en && !empty && !soft_rst;
  assign rd_entry_c  = mem_q[rd_ptr_q[ADDR_W-1:0]];
  assign d_out       = d_out_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    pkt_count_d = pkt_count_q;
    d_out_d     = d_out_q;

    if (soft_rst) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      pkt_count_d = '0;
      d_out_d     = '0;
    end else begin
      if (wr_accept_c) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (rd_accept_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        d_out_d  = rd_entry_c[WIDTH-1:0];
        // Header load counts payload bytes plus the trailing parity byte.
        if (rd_entry_c[WIDTH]) begin
          pkt_count_d = rd_entry_c[LEN_MSB:LEN_LSB] + CNT_W'(1);
        end else if (pkt_count_q != '0) begin
          pkt_count_d = pkt_count_q - CNT_W'(1);
        end
      end else if (pkt_count_q == '0) begin
        d_out_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pkt_count_q <= '0;
      d_out_q     <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pkt_count_q <= pkt_count_d;
      d_out_q     <= d_out_d;
    end
  end

  // Storage is not reset; only the pointers define valid contents.
  always_ff @(posedge clk) begin
    if (wr_accept_c) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= {lfd_state, d_in};
    end
  end

endmodule

// File: tb/tb_router_fifo.sv
// Randomized self-checking bench for router_fifo against a queue-based model
// of the packet buffer and its read-side length counter.
module tb_router_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       soft_rst;
  logic       wr_en;
  logic       rd_en;
  logic       lfd_state;
  logic [7:0] d_in;
  logic [7:0] d_out;
  logic       full;
  logic       empty;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] mq[$];
  int         m_cnt  = 0;
  logic [7:0] m_dout = 8'h00;

  router_fifo #(.WIDTH(8), .DEPTH(16), .ADDR_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .soft_rst  (soft_rst),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .lfd_state (lfd_state),
    .d_in      (d_in),
    .d_out     (d_out),
    .full      (full),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  function automatic void model_clear();
    mq.delete();
    m_cnt  = 0;
    m_dout = 8'h00;
  endfunction

  // One clock: drive inputs, advance the model on the edge, settle #1 after it.
  task automatic cycle(input logic wr, input logic rd, input logic lfd,
                       input logic [7:0] din, input logic srst);
    logic       rd_ok;
    logic       wr_ok;
    logic [8:0] e;
    wr_en = wr; rd_en = rd; lfd_state = lfd; d_in = din; soft_rst = srst;
    @(posedge clk);
    if (srst) begin
      model_clear();
    end else begin
      rd_ok = rd && (mq.size() > 0);
      wr_ok = wr && (mq.size() < DEPTH);
      if (rd_ok) begin
        e = mq.pop_front();
        m_dout = e[7:0];
        if (e[8]) m_cnt = (int'(e[7:2]) + 1) % 64;
        else if (m_cnt > 0) m_cnt = m_cnt - 1;
      end else if (m_cnt == 0) begin
        m_dout = 8'h00;
      end
      if (wr_ok) mq.push_back({lfd, din});
    end
    #1;
    wr_en = 1'b0; rd_en = 1'b0; lfd_state = 1'b0; d_in = 8'h00; soft_rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; soft_rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; lfd_state = 1'b0; d_in = 8'h00;
    #12;
    n_checks++;
    if (empty !== 1'b1 || full !== 1'b0 || d_out !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state: empty=%b full=%b d_out=%h, required 1 0 00", empty, full, d_out);
    end
    n_checks++;
    if (dut.pkt_count_q !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_pkt_count: got %0d required 0", dut.pkt_count_q);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    model_clear();
  endtask

  task automatic test_single_packet();
    logic [7:0] exp_d [5];
    int         exp_c [5];
    exp_d = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h44};
    exp_c = '{4, 3, 2, 1, 0};
    cycle(1'b1, 1'b0, 1'b1, 8'h0D, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 8'h11, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 8'h22, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 8'h33, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 8'h44, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      n_checks++;
      if (d_out !== exp_d[i]) begin
        n_fail++;
        $display("FAIL single_d_out[%0d]: got %h required %h", i, d_out, exp_d[i]);
      end
      n_checks++;
      if (int'(dut.pkt_count_q) != exp_c[i]) begin
        n_fail++;
        $display("FAIL single_pkt_count[%0d]: got %0d required %0d", i, dut.pkt_count_q, exp_c[i]);
      end
    end
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    n_checks++;
    if (d_out !== 8'h00 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL single_idle: d_out=%h empty=%b, required 00 1", d_out, empty);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 8'($urandom), 1'b0);
      n_checks++;
      if (full !== (i == DEPTH - 1)) begin
        n_fail++;
        $display("FAIL fill_full[%0d]: got %b required %b", i, full, (i == DEPTH - 1));
      end
    end
    cycle(1'b1, 1'b1, 1'b0, 8'hEE, 1'b0);
    n_checks++;
    if (full !== 1'b0 || d_out !== m_dout || mq.size() != DEPTH - 1) begin
      n_fail++;
      $display("FAIL fill_overwrite: full=%b d_out=%h, required 0 %h", full, d_out, m_dout);
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      n_checks++;
      if (d_out !== m_dout) begin
        n_fail++;
        $display("FAIL fill_drain[%0d]: got %h required %h", i, d_out, m_dout);
      end
    end
    n_checks++;
    if (empty !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_dropped_write: empty=%b required 1", empty);
    end
  endtask

  task automatic test_wrap();
    logic wr;
    logic rd;
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, ($urandom_range(0, 3) == 0), 8'($urandom), 1'b0);
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 1'b1, ($urandom_range(0, 3) == 0), 8'($urandom), 1'b0);
      n_checks++;
      if (d_out !== m_dout || full !== 1'b0 || empty !== 1'b0 || int'(dut.pkt_count_q) != m_cnt) begin
        n_fail++;
        $display("FAIL wrap_steady[%0d]: d_out=%h full=%b empty=%b cnt=%0d, required %h 0 0 %0d",
                 i, d_out, full, empty, dut.pkt_count_q, m_dout, m_cnt);
      end
    end
    for (int i = 0; i < 300; i++) begin
      wr = (i < 150) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      rd = (i < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      cycle(wr, rd, ($urandom_range(0, 4) == 0), 8'($urandom), 1'b0);
      n_checks++;
      if (d_out !== m_dout || full !== (mq.size() == DEPTH) || empty !== (mq.size() == 0) ||
          int'(dut.pkt_count_q) != m_cnt) begin
        n_fail++;
        $display("FAIL wrap_random[%0d]: d_out=%h full=%b empty=%b cnt=%0d, required %h %b %b %0d",
                 i, d_out, full, empty, dut.pkt_count_q, m_dout, (mq.size() == DEPTH),
                 (mq.size() == 0), m_cnt);
      end
    end
    for (int i = 0; i < DEPTH + 2 && mq.size() > 0; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    n_checks++;
    if (empty !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_drain: empty=%b required 1", empty);
    end
  endtask

  task automatic test_soft_reset();
    cycle(1'b1, 1'b0, 1'b1, 8'h14, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 8'(8'h60 + i), 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    n_checks++;
    if (d_out !== 8'h60 || dut.pkt_count_q !== 6'd5) begin
      n_fail++;
      $display("FAIL soft_pre: d_out=%h cnt=%0d, required 60 5", d_out, dut.pkt_count_q);
    end
    cycle(1'b1, 1'b1, 1'b1, 8'hAA, 1'b1);
    n_checks++;
    if (empty !== 1'b1 || d_out !== 8'h00 || dut.pkt_count_q !== 6'd0 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL soft_flush: empty=%b d_out=%h cnt=%0d full=%b, required 1 00 0 0",
               empty, d_out, dut.pkt_count_q, full);
    end
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    n_checks++;
    if (empty !== 1'b1 || d_out !== 8'h00) begin
      n_fail++;
      $display("FAIL soft_write_dropped: empty=%b d_out=%h, required 1 00", empty, d_out);
    end
  endtask

  task automatic test_empty_read();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      n_checks++;
      if (d_out !== 8'h00 || empty !== 1'b1) begin
        n_fail++;
        $display("FAIL empty_read[%0d]: d_out=%h empty=%b, required 00 1", i, d_out, empty);
      end
    end
    cycle(1'b1, 1'b0, 1'b0, 8'h5A, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    n_checks++;
    if (d_out !== 8'h5A || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_read_after: d_out=%h empty=%b, required 5a 1", d_out, empty);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 8'(8'h80 | 8'($urandom)), 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    n_checks++;
    if (d_out !== m_dout || mq.size() != 5 || empty !== 1'b0) begin
      n_fail++;
      $display("FAIL async_pre: d_out=%h empty=%b, required %h 0", d_out, empty, m_dout);
    end
    rst = 1'b0;
    #2;
    n_checks++;
    if (empty !== 1'b1 || full !== 1'b0 || d_out !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset: empty=%b full=%b d_out=%h, required 1 0 00", empty, full, d_out);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    model_clear();
    cycle(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    n_checks++;
    if (dut.pkt_count_q !== 6'd1 || d_out !== 8'h00) begin
      n_fail++;
      $display("FAIL zero_len_header: cnt=%0d d_out=%h, required 1 00", dut.pkt_count_q, d_out);
    end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_fill();
    test_wrap();
    test_soft_reset();
    test_empty_read();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/router_fifo.md
Name: router_fifo

Overview:
- Per-destination output buffer of the 1x3 router.
- Three instances sit directly downstream of router_synchronizer:
  - Each instance takes one bit of its wr_en bus and its soft_rst_N.
  - Each returns full_N / empty_N to the synchronizer.
- Stores packet bytes from the register stage, tagged with a header marker. Drives d_out to the destination reader.
- Tracks packet length on the read side so the output bus idles cleanly between packets.

Parameters:
- WIDTH, 8, data byte width (header length field fixed at d_in[7:2]).
- DEPTH, 16, number of storage entries (power of two).
- ADDR_W, 4, log2(DEPTH); pointers are ADDR_W+1 bits.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous active-low reset.
- soft_rst  input  1  synchronous flush from synchronizer (read timeout).
- wr_en  input  1  write request (one bit of synchronizer wr_en).
- rd_en  input  1  read request from destination.
- lfd_state  input  1  high when the byte on d_in is a packet header.
- d_in  input  WIDTH  byte to write.
- d_out  output  WIDTH  registered read data.
- full  output  1  no free entry.
- empty  output  1  no stored entry.

Behaviour:
- Storage: DEPTH entries of WIDTH+1 bits = {lfd_state, d_in}.
- Pointers: wr_ptr and rd_ptr, ADDR_W+1 bits each.
  - empty = (wr_ptr == rd_ptr).
  - full = MSBs differ and low ADDR_W bits equal.
  - Both are combinational from the registered pointers.
- rst low (async): pointers, pkt_count, d_out cleared to 0 immediately → empty=1, full=0. Memory contents not cleared.
- soft_rst high (sync, priority over rd/wr same cycle):
  - Pointers, pkt_count, d_out cleared to 0 next edge.
  - A write or read in that cycle is discarded.
- Write: when wr_en && !full, mem[wr_ptr[ADDR_W-1:0]] <= {lfd_state, d_in} and wr_ptr+1.
  - Write with full=1 is ignored, even if a read occurs the same cycle.
- Read: when rd_en && !empty, d_out <= mem[rd_ptr][WIDTH-1:0] and rd_ptr+1.
  - Latency: 1 cycle (data visible the cycle after the rd_en edge).
  - Read with empty=1 is ignored.
- Simultaneous read and write with 0 < occupancy < DEPTH: both proceed, occupancy unchanged.
- Pointer wrap: natural modulo 2^(ADDR_W+1); no special case at DEPTH.
- pkt_count (6 bits):
  - On a read of an entry whose tag bit is 1: pkt_count <= d[7:2] + 1 (payload bytes + parity).
  - On a read of an untagged entry with pkt_count != 0: pkt_count - 1.
  - Never decrements below 0.
- Idle output: when pkt_count == 0 and no read is accepted this cycle, d_out <= 0. Otherwise d_out holds its last value while stalled mid-packet.
- No tristate output.
- Header length 0 is legal: count loads 1, then parity read brings it to 0.

Test Plan:
- Reset: hold rst=0 mid-run with 5 stored entries → empty=1, full=0, d_out=0 asynchronously, before the next clk edge.
- Single packet: write header 8'h0D (len 3, lfd_state=1), payload 11,22,33, parity 44. Then read 5 cycles → d_out = 0D,11,22,33,44 at one-cycle latency; pkt_count 4,3,2,1,0; d_out=0 on the following idle cycle; empty=1.
- Fill: 16 writes with no reads → full=1 after the 16th. A 17th write with rd_en=1 the same cycle → read accepted, write dropped. Occupancy 15, full=0.
- Wrap: interleave 40 writes and reads at occupancy 8 → data order preserved; pointers wrap twice; full/empty never glitch.
- Soft reset mid-packet: header 8'h14 (len 5), read 2 bytes, then assert soft_rst with wr_en=1 and rd_en=1 → next cycle empty=1, d_out=0, pkt_count=0, and the concurrent write is not stored.
- Empty read: rd_en=1 with empty=1 for 3 cycles → pointers unchanged, d_out stays 0.
